// File: rtl/dlx_pkg.sv
// Shared types and default constants for the DLX fetch path.
package dlx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int DLX_IR_SIZE    = 32;
  localparam int DLX_PC_SIZE    = 32;
  localparam int DLX_FIFO_DEPTH = 4;
  localparam int DLX_PC_INC     = 4;
  localparam int DLX_RESET_PC   = 0;

endpackage

// File: rtl/dlx_ir_fifo.sv
// Synchronous prefetch FIFO with flush; head is visible combinationally on rdata.
module dlx_ir_fifo
  import dlx_pkg::*;
#(
  parameter int WIDTH = DLX_IR_SIZE,
  parameter int DEPTH = DLX_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             wr, rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem[rptr_q];
  assign wr    = push && !full && !flush;
  assign rd    = pop && !empty && !flush;

  // Storage is data only and carries no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction fetch: credit-limited memory requests, in-order prefetch FIFO, redirect flush.
module dlx_fetch_unit
  import dlx_pkg::*;
#(
  parameter int IR_SIZE    = DLX_IR_SIZE,
  parameter int PC_SIZE    = DLX_PC_SIZE,
  parameter int FIFO_DEPTH = DLX_FIFO_DEPTH,
  parameter int PC_INC     = DLX_PC_INC,
  parameter int RESET_PC   = DLX_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_i,
  input  logic [PC_SIZE-1:0] target_i,
  output logic               imem_req_o,
  output logic [PC_SIZE-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [IR_SIZE-1:0] imem_rdata_i,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  output logic [IR_SIZE-1:0] ir_o,
  output logic [PC_SIZE-1:0] pc_o,
  output logic [PC_SIZE-1:0] npc_o
);
  localparam int                 CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PC_SIZE-1:0] INC    = PC_SIZE'(PC_INC);
  localparam logic [PC_SIZE-1:0] RST_PC = PC_SIZE'(RESET_PC);

  fetch_state_t       state_q, state_d;
  logic [PC_SIZE-1:0] fetch_pc_q, pc_q;
  logic [CW-1:0]      out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CW:0]        credit;
  logic               grant, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [IR_SIZE-1:0] fifo_head;

  // Credit covers both buffered and in-flight words so a response always finds room.
  assign credit     = {1'b0, fifo_count} + {1'b0, out_q};
  assign imem_req_o = (state_q == RUN) && fetch_en && (credit < (CW+1)'(FIFO_DEPTH));
  assign grant      = imem_req_o && imem_gnt_i;
  assign fifo_push  = (state_q == RUN) && imem_rvalid_i && !redirect_i;
  assign fifo_pop   = ir_valid_o && ir_ready_i && !redirect_i;
  assign out_d      = out_q + CW'(grant) - CW'(imem_rvalid_i);

  assign imem_addr_o = fetch_pc_q;
  assign ir_valid_o  = !fifo_empty;
  assign ir_o        = fifo_empty ? '0 : fifo_head;
  assign pc_o        = pc_q;
  assign npc_o       = pc_q + INC;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          drop_d = out_d;
          if (out_d != '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (redirect_i) begin
          drop_d = out_d;
        end else begin
          if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
          if (drop_d == '0) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      pc_q       <= RST_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (redirect_i) begin
        fetch_pc_q <= target_i;
        pc_q       <= target_i;
      end else begin
        if (grant)    fetch_pc_q <= fetch_pc_q + INC;
        if (fifo_pop) pc_q       <= pc_q + INC;
      end
    end
  end

  dlx_ir_fifo #(
    .WIDTH (IR_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (fifo_push),
    .wdata (imem_rdata_i),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Scoreboard bench for dlx_fetch_unit with an in-order instruction memory model.
module tb_dlx_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ir_valid_o;
  logic        ir_ready_i;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic [31:0] npc_o;

  int          tests = 0;
  int          fails = 0;
  int          issued;
  int          stale_seen;
  int          epoch = 0;
  int          resp_epoch;
  logic        resp_hold;
  logic        expect_valid;
  req_t        mem_q[$];
  logic [31:0] sb[$];
  logic [31:0] popped[$];

  always #5 clk = ~clk;

  dlx_fetch_unit #(
    .IR_SIZE(32), .PC_SIZE(32), .FIFO_DEPTH(4), .PC_INC(4), .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ir_valid_o    (ir_valid_o),
    .ir_ready_i    (ir_ready_i),
    .ir_o          (ir_o),
    .pc_o          (pc_o),
    .npc_o         (npc_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Mid-cycle view of the handshakes that the next rising edge will commit.
  task automatic observe();
    logic [31:0] exp;
    if (expect_valid) begin
      tests++;
      if (ir_valid_o !== 1'b1) begin
        fails++;
        $display("FAIL resp_latency: ir_valid_o=%b required 1", ir_valid_o);
      end
    end
    expect_valid = 1'b0;
    if (imem_rvalid_i) begin
      if (resp_epoch == epoch && !redirect_i) expect_valid = 1'b1;
      else stale_seen++;
    end
    if (ir_valid_o && ir_ready_i && !redirect_i) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: pc_o=%h ir_o=%h required no instruction", pc_o, ir_o);
      end else begin
        exp = sb.pop_front();
        if (pc_o !== exp || ir_o !== mem_word(exp) || npc_o !== exp + 32'd4) begin
          fails++;
          $display("FAIL pop_data: pc=%h ir=%h npc=%h required pc=%h ir=%h npc=%h",
                   pc_o, ir_o, npc_o, exp, mem_word(exp), exp + 32'd4);
        end
        popped.push_back(pc_o);
      end
    end
    if (imem_req_o && imem_gnt_i) begin
      issued++;
      mem_q.push_back('{addr: imem_addr_o, epoch: epoch});
      if (!redirect_i) sb.push_back(imem_addr_o);
    end
    if (redirect_i) begin
      epoch++;
      sb.delete();
    end
  endtask

  task automatic mem_drive();
    req_t e;
    if (!rst) begin
      imem_rvalid_i = 1'b0;
      mem_q.delete();
    end else if (!resp_hold && mem_q.size() > 0) begin
      e = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(e.addr);
      resp_epoch    = e.epoch;
    end else begin
      imem_rvalid_i = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst) observe();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic clear_bench();
    mem_q.delete();
    sb.delete();
    popped.delete();
    expect_valid  = 1'b0;
    issued        = 0;
    stale_seen    = 0;
    imem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_en = 1'b0; redirect_i = 1'b0; target_i = '0;
    imem_gnt_i = 1'b0; ir_ready_i = 1'b0; resp_hold = 1'b0;
    imem_rdata_i = '0;
    clear_bench();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain();
    fetch_en = 1'b0; ir_ready_i = 1'b1; imem_gnt_i = 1'b1; resp_hold = 1'b0;
    for (int i = 0; i < 50 && (sb.size() != 0 || mem_q.size() != 0 || ir_valid_o); i++) tick();
    tests++;
    if (sb.size() != 0 || ir_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drain: pending=%0d ir_valid_o=%b required 0 and 0", sb.size(), ir_valid_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: %b required 0", imem_req_o); end
    tests++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL rst_addr: %h required 0", imem_addr_o); end
    tests++; if (ir_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: %b required 0", ir_valid_o); end
    tests++; if (ir_o !== 32'h0) begin fails++; $display("FAIL rst_ir: %h required 0", ir_o); end
    tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL rst_pc: %h required 0", pc_o); end
    tests++; if (npc_o !== 32'h4) begin fails++; $display("FAIL rst_npc: %h required 4", npc_o); end
    @(posedge clk); #1 rst = 1'b1;
    fetch_en = 1'b1;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL idle_req: %b required 0", imem_req_o); end
    tick();
    #1;
    tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL run_req: req=%b addr=%h required 1 and 0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b1; ir_ready_i = 1'b1;
    for (int i = 0; i < 40 && popped.size() < 4; i++) tick();
    tests++;
    if (popped.size() < 4) begin
      fails++;
      $display("FAIL stream_timeout: %0d pops required 4", popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (popped[i] !== 32'(i * 4)) begin
          fails++;
          $display("FAIL stream_pc%0d: %h required %h", i, popped[i], 32'(i * 4));
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b1; ir_ready_i = 1'b0;
    repeat (10) tick();
    tests++; if (issued != 4) begin fails++; $display("FAIL bp_issued: %0d required 4", issued); end
    #1;
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL bp_req_full: %b required 0", imem_req_o); end
    ir_ready_i = 1'b1;
    tick();
    ir_ready_i = 1'b0;
    #1;
    tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      fails++;
      $display("FAIL bp_req_after_pop: req=%b addr=%h required 1 and 10", imem_req_o, imem_addr_o);
    end
    drain();
  endtask

  task automatic test_redirect_flush();
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b1; ir_ready_i = 1'b0; resp_hold = 1'b1;
    for (int i = 0; i < 20 && issued < 2; i++) tick();
    fetch_en = 1'b0;
    tests++; if (issued != 2) begin fails++; $display("FAIL flush_setup: %0d required 2", issued); end
    redirect_i = 1'b1; target_i = 32'h100;
    tick();
    redirect_i = 1'b0; fetch_en = 1'b1; resp_hold = 1'b0; ir_ready_i = 1'b1;
    #1;
    tests++; if (ir_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: %b required 0", ir_valid_o); end
    tests++; if (pc_o !== 32'h100) begin fails++; $display("FAIL flush_pc: %h required 100", pc_o); end
    tests++; if (npc_o !== 32'h104) begin fails++; $display("FAIL flush_npc: %h required 104", npc_o); end
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL flush_req: %b required 0", imem_req_o); end
    popped.delete();
    for (int i = 0; i < 30 && popped.size() < 1; i++) tick();
    tests++;
    if (popped.size() < 1 || popped[0] !== 32'h100) begin
      fails++;
      $display("FAIL flush_first: pops=%0d required first pc 100", popped.size());
    end
    tests++; if (stale_seen != 2) begin fails++; $display("FAIL flush_dropped: %0d required 2", stale_seen); end
    drain();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b0; ir_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
        fails++;
        $display("FAIL stall_hold%0d: req=%b addr=%h required 1 and 0", i, imem_req_o, imem_addr_o);
      end
    end
    redirect_i = 1'b1; target_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    #1;
    tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      fails++;
      $display("FAIL stall_redirect: req=%b addr=%h required 1 and 200", imem_req_o, imem_addr_o);
    end
    imem_gnt_i = 1'b1; ir_ready_i = 1'b1;
    popped.delete();
    for (int i = 0; i < 30 && popped.size() < 1; i++) tick();
    tests++;
    if (popped.size() < 1 || popped[0] !== 32'h200) begin
      fails++;
      $display("FAIL stall_first: pops=%0d required first pc 200", popped.size());
    end
    drain();
  endtask

  task automatic test_redirect_pop_resp();
    logic found;
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b1; ir_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #1;
      if (ir_valid_o && imem_rvalid_i) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL coinc_setup: found=%b required 1", found); end
    redirect_i = 1'b1; target_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    #1;
    tests++;
    if (ir_valid_o !== 1'b0 || pc_o !== 32'h300) begin
      fails++;
      $display("FAIL coinc_after: valid=%b pc=%h required 0 and 300", ir_valid_o, pc_o);
    end
    popped.delete();
    for (int i = 0; i < 30 && popped.size() < 1; i++) tick();
    tests++;
    if (popped.size() < 1 || popped[0] !== 32'h300) begin
      fails++;
      $display("FAIL coinc_first: pops=%0d required first pc 300", popped.size());
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_en = 1'b1; imem_gnt_i = 1'b1; ir_ready_i = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b0;
    clear_bench();
    #1;
    tests++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || ir_valid_o !== 1'b0 ||
        ir_o !== 32'h0 || pc_o !== 32'h0 || npc_o !== 32'h4) begin
      fails++;
      $display("FAIL midrst_outputs: req=%b addr=%h valid=%b ir=%h pc=%h npc=%h required 0 0 0 0 0 4",
               imem_req_o, imem_addr_o, ir_valid_o, ir_o, pc_o, npc_o);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 30 && popped.size() < 1; i++) tick();
    tests++;
    if (popped.size() < 1 || popped[0] !== 32'h0) begin
      fails++;
      $display("FAIL midrst_restart: pops=%0d required first pc 0", popped.size());
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_gnt_stall();
    test_redirect_pop_resp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dlx_fetch_unit.md
DLX_FETCH_UNIT -- requirements
Module: dlx_fetch_unit

Interface
REQ-001 SHALL have parameter IR_SIZE, 32, instruction width in bits.
REQ-002 SHALL have parameter PC_SIZE, 32, program counter width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, prefetch buffer entries; power of 2, >=2.
REQ-004 SHALL have parameter PC_INC, 4, byte increment per instruction.
REQ-005 SHALL have parameter RESET_PC, 0, first fetch address.
REQ-006 SHALL have one clock and an asynchronous active-low reset, ports in this order:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active low
fetch_en  in  1  permits new memory requests
redirect_i  in  1  jump/branch taken; flush and refetch
target_i  in  PC_SIZE  redirect address
imem_req_o  out  1  instruction memory request
imem_addr_o  out  PC_SIZE  request address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  IR_SIZE  response instruction
ir_valid_o  out  1  instruction available to decode
ir_ready_i  in  1  decode accepts instruction
ir_o  out  IR_SIZE  head instruction
pc_o  out  PC_SIZE  address of ir_o
npc_o  out  PC_SIZE  pc_o + PC_INC

Function
REQ-007 SHALL implement FSM states IDLE, RUN, FLUSH; reset -> IDLE; IDLE -> RUN next cycle unconditionally.
REQ-008 SHALL assert imem_req_o only in RUN with fetch_en=1 and (fifo_count + outstanding) < FIFO_DEPTH.
REQ-009 SHALL hold imem_addr_o stable while imem_req_o=1 and imem_gnt_i=0, except on redirect.
REQ-010 SHALL on req&&gnt increment fetch PC by PC_INC (modulo 2^PC_SIZE) and outstanding by 1.
REQ-011 SHALL accept responses in request order; each imem_rvalid_i decrements outstanding; in RUN, data is written into the FIFO.
REQ-012 SHALL present FIFO head on ir_o with ir_valid_o=!empty; pop on ir_valid_o&&ir_ready_i, advancing pc_o by PC_INC.
REQ-013 SHALL have zero-cycle combinational path from FIFO head to ir_o; response-to-ir_valid_o latency exactly 1 cycle.
REQ-014 SHALL on redirect_i: clear FIFO, set fetch PC and pc_o to target_i, load drop count = outstanding (including a grant and minus a response in the same cycle); ir_valid_o=0 next cycle.
REQ-015 SHALL go to FLUSH on redirect if the resulting drop count > 0, else stay in RUN; FLUSH discards responses, decrementing drop count; FLUSH -> RUN when it reaches 0.
REQ-016 SHALL in FLUSH issue no requests; a redirect in FLUSH updates target and stays in FLUSH.
REQ-017 SHALL give redirect priority over simultaneous pop, response write and grant-address.
REQ-018 SHALL, when FIFO is full, never receive a response (guaranteed by REQ-008 credit); overflow SHALL be flagged by assertion.
REQ-019 SHALL size fifo_count, outstanding and drop counters log2(FIFO_DEPTH)+1 bits.

Reset
REQ-020 SHALL on rst=0 asynchronously set: state IDLE, imem_req_o=0, imem_addr_o=RESET_PC, ir_valid_o=0, ir_o=0, pc_o=RESET_PC, npc_o=RESET_PC+PC_INC, all counters 0, FIFO empty.
REQ-021 SHALL on reset mid-transaction discard outstanding requests; the memory is reset by the same rst.

Structure
REQ-022 SHALL place fetch_state_t (IDLE, RUN, FLUSH) and default parameter constants in shared package dlx_pkg.
REQ-023 SHALL instantiate one sub-module dlx_ir_fifo (synchronous FIFO, parametrised width/depth, flush input).

Verification
REQ-024 Reset then gnt=1, rvalid 1 cycle after grant, ready=1 -> pc_o sequence 0,4,8,12; ir_o matches memory words.
REQ-025 ready=0 for 10 cycles, gnt=1 -> exactly FIFO_DEPTH=4 requests issued, then imem_req_o=0 until a pop.
REQ-026 Redirect to 0x100 with 2 outstanding -> FLUSH, 2 responses discarded, next ir_o from 0x100, pc_o=0x100, npc_o=0x104.
REQ-027 gnt held 0 for 3 cycles -> imem_addr_o constant; redirect during wait -> imem_addr_o=target next cycle, drop count 0.
REQ-028 Redirect coincident with pop and response -> no instruction delivered from old stream; ir_valid_o=0 next cycle.
REQ-029 rst asserted mid-burst -> all outputs at REQ-020 values same cycle; restart fetches from RESET_PC.
